// File: rtl/camo_intc_pkg.sv
// Shared types and the lowest-set-bit encoder for the camouflaged priority interrupt controller.
package camo_intc_pkg;

  typedef enum logic [1:0] {
    CAMO_AND = 2'b00,
    CAMO_OR  = 2'b01,
    CAMO_XOR = 2'b10,
    CAMO_NOR = 2'b11
  } camo_fn_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } fsm_e;

  // Widest request vector the encoder supports; callers zero-extend into it.
  localparam int MAX_N = 64;

  function automatic int lowest_set(input logic [MAX_N-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/camo_cell2.sv
// Key-selected camouflaged mask cell; only select 00 (AND) yields the intended gating.
module camo_cell2
  import camo_intc_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = a & b;
    case (sel)
      CAMO_AND: y = a & b;
      CAMO_OR:  y = a | b;
      CAMO_XOR: y = a ^ b;
      CAMO_NOR: y = ~(a | b);
      default:  y = a & b;
    endcase
  end

endmodule

// File: rtl/camo_prio_intc.sv
// Pending-latch, camouflaged mask, fixed-priority arbiter with valid/ready handshake.
// Define CAMO_KEY_EN to build the serial key path; otherwise the mask is hardwired to AND.
module camo_prio_intc
  import camo_intc_pkg::*;
#(
  parameter int NUM_BUS    = 3,
  parameter int CH_PER_BUS = 9,
  parameter int ID_W       = $clog2(NUM_BUS * CH_PER_BUS),
  parameter int KEY_W      = 2 * NUM_BUS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_BUS*CH_PER_BUS-1:0]    req,
  input  logic [NUM_BUS*CH_PER_BUS-1:0]    en,
  output logic                             irq_valid,
  output logic [ID_W-1:0]                  irq_id,
  input  logic                             irq_ready,
  output logic [NUM_BUS-1:0]               bus_active,
  input  logic                             key_sin,
  input  logic                             key_shift,
  input  logic                             key_commit
);

  localparam int N = NUM_BUS * CH_PER_BUS;

  fsm_e              state_q, state_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N-1:0]      pending_q, pending_d, masked, clr;
  logic [NUM_BUS-1:0] bus_q, bus_d;
  logic [KEY_W-1:0]  key_sel;
  logic [ID_W-1:0]   winner;
  logic              any_masked, accept, commit_ok;

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    for (genvar c = 0; c < CH_PER_BUS; c++) begin : g_ch
      camo_cell2 u_cell (
        .sel (key_sel[2*b +: 2]),
        .a   (pending_q[b*CH_PER_BUS + c]),
        .b   (en[b*CH_PER_BUS + c]),
        .y   (masked[b*CH_PER_BUS + c])
      );
    end
    assign bus_d[b] = |masked[b*CH_PER_BUS +: CH_PER_BUS];
  end

  assign any_masked = |masked;
  assign winner     = ID_W'(lowest_set(MAX_N'(masked)));
  assign clr        = accept ? (N'(1) << id_q) : '0;
  // A fresh request outranks the clear of the id being accepted.
  assign pending_d  = req | (pending_q & ~clr);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    id_d      = id_q;
    accept    = 1'b0;
    commit_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_masked) begin
          id_d    = winner;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          commit_ok = 1'b1;
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          accept  = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      id_q      <= '0;
      pending_q <= '0;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      bus_q     <= bus_d;
    end
  end

`ifdef CAMO_KEY_EN
  logic [KEY_W-1:0] key_sr_q, key_sr_d, key_act_q, key_act_d;

  // Commit takes the pre-shift register so shift+commit in one cycle is well defined.
  assign key_sr_d  = key_shift ? {key_sr_q[KEY_W-2:0], key_sin} : key_sr_q;
  assign key_act_d = (key_commit && commit_ok) ? key_sr_q : key_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sr_q  <= '0;
      key_act_q <= '0;
    end else begin
      key_sr_q  <= key_sr_d;
      key_act_q <= key_act_d;
    end
  end

  assign key_sel = key_act_q;
`else
  logic unused_key;
  assign key_sel    = '0;
  assign unused_key = ^{key_sin, key_shift, key_commit, commit_ok};
`endif

  assign irq_valid  = valid_q;
  assign irq_id     = id_q;
  assign bus_active = bus_q;

endmodule

// File: tb/tb_camo_prio_intc.sv
// Self-checking bench: vector table plus hand-written handshake, key and reset sequences.
module tb_camo_prio_intc;

  localparam int N = 27;

  logic          clk, rst_n;
  logic [N-1:0]  req, en;
  logic          irq_valid, irq_ready;
  logic [4:0]    irq_id;
  logic [2:0]    bus_active;
  logic          key_sin, key_shift, key_commit;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] en;
    logic         vld;
    logic [4:0]   id;
    logic [2:0]   ba;
  } vec_t;

  vec_t vecs[8];

  camo_prio_intc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .en         (en),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ready  (irq_ready),
    .bus_active (bus_active),
    .key_sin    (key_sin),
    .key_shift  (key_shift),
    .key_commit (key_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    int e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got id 0x%0h expected none (scoreboard empty)", name, irq_id);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(irq_id), 32'(e));
    end
  endtask

  task automatic wait_grant(input string name, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (irq_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no irq_valid expected grant within %0d cycles", name, bound);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      pop_check(name);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req        = '0;
    en         = '1;
    irq_ready  = 1'b0;
    key_sin    = 1'b0;
    key_shift  = 1'b0;
    key_commit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic accept();
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
  endtask

  task automatic shift_key(input logic [5:0] k);
    for (int i = 5; i >= 0; i--) begin
      key_sin   = k[i];
      key_shift = 1'b1;
      @(negedge clk);
    end
    key_shift = 1'b0;
    key_sin   = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    @(negedge clk);
    key_commit = 1'b0;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, 32'(irq_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{27'h0000010, 27'h7FFFFFF, 1'b1, 5'd4,  3'b001};
    vecs[1] = '{27'h0000404, 27'h7FFFFFF, 1'b1, 5'd2,  3'b011};
    vecs[2] = '{27'h0100004, 27'h7FFFFFB, 1'b1, 5'd20, 3'b100};
    vecs[3] = '{27'h4000000, 27'h7FFFFFF, 1'b1, 5'd26, 3'b100};
    vecs[4] = '{27'h4000200, 27'h7FFFFFF, 1'b1, 5'd9,  3'b110};
    vecs[5] = '{27'h0000101, 27'h7FFFFFF, 1'b1, 5'd0,  3'b001};
    vecs[6] = '{27'h0000000, 27'h7FFFFFF, 1'b0, 5'd0,  3'b000};
    vecs[7] = '{27'h7FFFFFF, 27'h0000000, 1'b0, 5'd0,  3'b000};

    do_reset();
    check("reset_valid", 32'(irq_valid), 32'd0);
    check("reset_id", 32'(irq_id), 32'd0);
    check("reset_bus_active", 32'(bus_active), 32'd0);

    // Single-pulse vectors: grant visible two edges after the request edge.
    foreach (vecs[i]) begin
      do_reset();
      req = vecs[i].req;
      en  = vecs[i].en;
      if (vecs[i].vld) exp_q.push_back(int'(vecs[i].id));
      @(negedge clk);
      req = '0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(irq_valid), 32'(vecs[i].vld));
      if (irq_valid) pop_check($sformatf("vec%0d_id", i));
      check($sformatf("vec%0d_bus_active", i), 32'(bus_active), 32'(vecs[i].ba));
    end

    // Latency, hold under back-pressure, accept clears pending.
    do_reset();
    req = 27'h10;
    exp_q.push_back(4);
    @(negedge clk);
    req = '0;
    check("lat_not_yet", 32'(irq_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(irq_valid), 32'd1);
    pop_check("lat_id");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), 32'(irq_valid), 32'd1);
      check($sformatf("hold%0d_id", i), 32'(irq_id), 32'd4);
    end
    accept();
    check("acc_valid_drop", 32'(irq_valid), 32'd0);
    expect_quiet("acc_pending_clear", 3);

    // Back-to-back: 2 then 10 with exactly one idle cycle between.
    do_reset();
    req = 27'h404;
    exp_q.push_back(2);
    exp_q.push_back(10);
    @(negedge clk);
    req = '0;
    wait_grant("b2b_first", 4);
    accept();
    check("b2b_gap", 32'(irq_valid), 32'd0);
    @(negedge clk);
    check("b2b_second_valid", 32'(irq_valid), 32'd1);
    pop_check("b2b_second_id");
    accept();

    // Held request re-sets pending on the accept edge.
    do_reset();
    req = 27'h80;
    exp_q.push_back(7);
    exp_q.push_back(7);
    wait_grant("held_first", 4);
    accept();
    check("held_gap", 32'(irq_valid), 32'd0);
    @(negedge clk);
    check("held_re_valid", 32'(irq_valid), 32'd1);
    pop_check("held_re_id");
    req = '0;
    accept();
    expect_quiet("held_done", 3);

    // Key 000001 puts bus 0 in OR mode: enable alone raises channel 3.
    do_reset();
    en = 27'h8;
    shift_key(6'b000001);
    commit();
`ifdef CAMO_KEY_EN
    exp_q.push_back(3);
    wait_grant("key_or_grant", 4);
    en = '0;
    accept();
`else
    expect_quiet("key_ignored", 4);
    en = '0;
`endif
    shift_key(6'b000000);
    commit();
    en = '1;
    expect_quiet("key_recommit0", 4);

    // Commit during PRESENT is dropped; OR mode would grant id 3 afterwards.
    do_reset();
    req = 27'h20;
    exp_q.push_back(5);
    @(negedge clk);
    req = '0;
    wait_grant("pres_grant", 4);
    shift_key(6'b000001);
    commit();
    check("pres_id_stable", 32'(irq_id), 32'd5);
    en = 27'h8;
    accept();
    expect_quiet("pres_commit_ignored", 4);

    // Asynchronous reset while a winner is presented.
    do_reset();
    req = 27'h1000;
    exp_q.push_back(12);
    @(negedge clk);
    req = '0;
    wait_grant("rst_grant", 4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(irq_valid), 32'd0);
    check("rst_async_bus", 32'(bus_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("rst_pending_lost", 3);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/camo_prio_intc.md
# camo_prio_intc

Parametrised, sequential successor to the combinational 27-channel priority interrupt decoder. It latches interrupt requests into a pending register, masks them through key-selected camouflaged cells, arbitrates by fixed priority and presents one winner per handshake. It sits between the peripheral request lines and the CPU interrupt port. A serially loaded key selects each camouflaged cell's function; only the correct key yields correct masking.

## Interface
- NUM_BUS, 3, number of request buses (bus 0 highest priority)
- CH_PER_BUS, 9, channels per bus; N = NUM_BUS*CH_PER_BUS
- ID_W, $clog2(N), width of encoded channel id
- KEY_W, 2*NUM_BUS, key bits (2 per bus camo cell group)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  level request lines, channel c = bus*CH_PER_BUS + ch
- en  in  N  per-channel enable
- irq_valid  out  1  winner presented
- irq_id  out  ID_W  winning channel index
- irq_ready  in  1  consumer accepts winner
- bus_active  out  NUM_BUS  registered OR of masked pending per bus
- key_sin  in  1  key serial data
- key_shift  in  1  shift key_sin into key shift register (MSB first)
- key_commit  in  1  copy shift register to active key

## Operation
- Reset: pending=0, key_sr=0, key_act=0, irq_valid=0, irq_id=0, bus_active=0, FSM=IDLE.
- Pending: each cycle pending[c] <= req[c] | (pending[c] & ~clr[c]). clr is asserted only for the accepted id; set wins over clear on the same cycle.
- Masking: masked[c] = camo(key_act[2b+1:2b], pending[c], en[c]) for bus b. Functions: 00 AND (correct), 01 OR, 10 XOR, 11 NOR.
- Arbitration: the lowest-index set bit of masked wins, so lower bus wins, then lower channel.
- FSM IDLE: if any masked bit is set, register winner into irq_id, set irq_valid, go PRESENT.
- FSM PRESENT: irq_valid and irq_id are held stable. When irq_valid & irq_ready at an edge, clear pending[irq_id], drop irq_valid, go IDLE. A winner is never withdrawn, even if en or key changes.
- Key: key_shift shifts every cycle it is high, in any state: key_sr <= {key_sr[KEY_W-2:0], key_sin}.
- key_commit: honoured only in IDLE with no transition that cycle; it is ignored in PRESENT and must be re-issued. If key_shift and key_commit are both high, the pre-shift key_sr is committed.
- bus_active[b] <= |masked of bus b, updated every cycle.

## Timing
- req is sampled at edge t, pending is set after t, and irq_valid goes high after edge t+1 (2-cycle latency from IDLE).
- Back-to-back: after acceptance at edge t, FSM is in IDLE. The next winner is presented after edge t+1, giving 1 idle cycle between grants.
- bus_active lags pending by 1 cycle.
- Reset mid-PRESENT: irq_valid drops immediately (async) and all pending state is lost.

## Configuration
- CAMO_KEY_EN defined: key_sr, key_act and 2-bit camo cells are present, as described above.
- CAMO_KEY_EN undefined:
  - masked = pending & en, hardwired.
  - key_sin, key_shift and key_commit are ignored; no key flops are built.
  - Behaviour equals the defined case with key_act=0.

## Structure
- Package camo_intc_pkg holds:
  - camo_fn_e enum (CAMO_AND=2'b00, CAMO_OR, CAMO_XOR, CAMO_NOR)
  - fsm_e {IDLE, PRESENT}
  - a function for the lowest-set-bit encoder.
- One sub-module, camo_cell2: 2-bit select, inputs a and b, output y. It is instantiated N times, sharing the key per bus.

## Test plan
- Reset then req[4]=1 with en all ones and key 0 → irq_valid=1 after 2 edges with irq_id=4. Hold irq_ready=0 for 5 cycles → id stays 4. Pulse ready → pending[4]=0 and valid drops.
- req[10] and req[2] together → id 2 is granted first, then id 10 one idle cycle after the first accept.
- en[2]=0 with req[2],req[20] → only 20 is granted, and bus_active=3'b100.
- Shift key 6'b000001 and commit in IDLE (bus 0 OR mode), with req=0 and en[3]=1 → irq_id=3 without any request. Recommit 0 → no spurious grant.
- Hold req[7] while accepting id 7 → pending re-sets and id 7 is re-presented after 1 idle cycle.
- key_commit during PRESENT → key_act unchanged. Assert rst_n=0 mid-PRESENT → irq_valid=0 immediately and pending=0.
